gray2rgb: RTL and testbench

GRAY2RGB -- requirements
Module: gray2rgb

---
 rtl/gray2rgb_pkg.sv | 19 +
 rtl/gray2rgb_colormap.sv | 58 +++++
 rtl/gray2rgb.sv | 116 +++++++++++
 tb/tb_gray2rgb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gray2rgb_pkg.sv
// Shared types for the gray-to-RGB colouriser: output mode and heat-map segment.
package gray2rgb_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    MODE_GRAY = 1'b0,
    MODE_HEAT = 1'b1
  } mode_e;

  // Heat map runs blue -> cyan -> green -> yellow -> red in four equal segments.
  typedef enum logic [1:0] {
    SEG_B2C = 2'd0,
    SEG_C2G = 2'd1,
    SEG_G2Y = 2'd2,
    SEG_Y2R = 2'd3
  } seg_e;

endpackage

// File: rtl/gray2rgb_colormap.sv
// Combinational map from registered gray/segment/ramp to an RGB triple.
module gray2rgb_colormap
  import gray2rgb_pkg::*;
#(
  parameter int width_p = WIDTH_DEFAULT
) (
  input  mode_e              mode_i,
  input  logic [width_p-1:0] gray_i,
  input  seg_e               seg_i,
  input  logic [width_p-1:0] ramp_i,
  output logic [width_p-1:0] red_o,
  output logic [width_p-1:0] green_o,
  output logic [width_p-1:0] blue_o
);

  localparam logic [width_p-1:0] MaxVal = {width_p{1'b1}};

  logic [width_p-1:0] ramp_inv;

  // ramp_i never exceeds MaxVal, so the subtraction cannot wrap.
  assign ramp_inv = MaxVal - ramp_i;

  always_comb begin
    red_o   = gray_i;
    green_o = gray_i;
    blue_o  = gray_i;
    if (mode_i == MODE_HEAT) begin
      unique case (seg_i)
        SEG_B2C: begin
          red_o   = '0;
          green_o = ramp_i;
          blue_o  = MaxVal;
        end
        SEG_C2G: begin
          red_o   = '0;
          green_o = MaxVal;
          blue_o  = ramp_inv;
        end
        SEG_G2Y: begin
          red_o   = ramp_i;
          green_o = MaxVal;
          blue_o  = '0;
        end
        SEG_Y2R: begin
          red_o   = MaxVal;
          green_o = ramp_inv;
          blue_o  = '0;
        end
        default: begin
          red_o   = '0;
          green_o = '0;
          blue_o  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gray2rgb.sv
// Two-stage valid/ready pipeline: S1 holds the sample and heat-map decode, S2 the RGB result.
module gray2rgb
  import gray2rgb_pkg::*;
#(
  parameter int width_p = WIDTH_DEFAULT
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  input  logic [width_p-1:0] gray_i,
  input  logic               mode_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] red_o,
  output logic [width_p-1:0] green_o,
  output logic [width_p-1:0] blue_o,
  input  logic               ready_i
);

  logic               v1_q, v1_d;
  logic [width_p-1:0] gray1_q, gray1_d;
  mode_e              mode1_q, mode1_d;
  seg_e               seg1_q, seg1_d;
  logic [width_p-1:0] ramp1_q, ramp1_d;

  logic               v2_q, v2_d;
  logic [width_p-1:0] red2_q, red2_d;
  logic [width_p-1:0] green2_q, green2_d;
  logic [width_p-1:0] blue2_q, blue2_d;

  logic               advance;
  logic [width_p-3:0] frac;
  logic [width_p-1:0] ramp_in;
  logic [width_p-1:0] map_red, map_green, map_blue;

  assign advance = ~v2_q | ready_i;
  assign ready_o = ~v1_q | advance;

  // Ramp repeats the top fraction bits so that an all-ones fraction reaches full scale.
  assign frac    = gray_i[width_p-3:0];
  assign ramp_in = {frac, frac[width_p-3:width_p-4]};

  gray2rgb_colormap #(
    .width_p (width_p)
  ) u_colormap (
    .mode_i  (mode1_q),
    .gray_i  (gray1_q),
    .seg_i   (seg1_q),
    .ramp_i  (ramp1_q),
    .red_o   (map_red),
    .green_o (map_green),
    .blue_o  (map_blue)
  );

  always_comb begin
    v1_d     = v1_q;
    gray1_d  = gray1_q;
    mode1_d  = mode1_q;
    seg1_d   = seg1_q;
    ramp1_d  = ramp1_q;
    v2_d     = v2_q;
    red2_d   = red2_q;
    green2_d = green2_q;
    blue2_d  = blue2_q;

    // S1 data only changes on a real input transfer.
    if (ready_o) begin
      v1_d = valid_i;
      if (valid_i) begin
        gray1_d = gray_i;
        mode1_d = mode_e'(mode_i);
        seg1_d  = seg_e'(gray_i[width_p-1:width_p-2]);
        ramp1_d = ramp_in;
      end
    end

    if (advance) begin
      v2_d = v1_q;
      if (v1_q) begin
        red2_d   = map_red;
        green2_d = map_green;
        blue2_d  = map_blue;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1_q     <= 1'b0;
      gray1_q  <= '0;
      mode1_q  <= MODE_GRAY;
      seg1_q   <= SEG_B2C;
      ramp1_q  <= '0;
      v2_q     <= 1'b0;
      red2_q   <= '0;
      green2_q <= '0;
      blue2_q  <= '0;
    end else begin
      v1_q     <= v1_d;
      gray1_q  <= gray1_d;
      mode1_q  <= mode1_d;
      seg1_q   <= seg1_d;
      ramp1_q  <= ramp1_d;
      v2_q     <= v2_d;
      red2_q   <= red2_d;
      green2_q <= green2_d;
      blue2_q  <= blue2_d;
    end
  end

  assign valid_o = v2_q;
  assign red_o   = red2_q;
  assign green_o = green2_q;
  assign blue_o  = blue2_q;

endmodule

// File: tb/tb_gray2rgb.sv
// Directed bench for gray2rgb: vector table, backpressure, streaming and mid-stream reset.
module tb_gray2rgb;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       valid_i;
  logic [7:0] gray_i;
  logic       mode_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] red_o, green_o, blue_o;
  logic       ready_i;
  logic [23:0] rgb;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0]  gray;
    logic        mode;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[16];

  gray2rgb #(.width_p(8)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .gray_i   (gray_i),
    .mode_i   (mode_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .red_o    (red_o),
    .green_o  (green_o),
    .blue_o   (blue_o),
    .ready_i  (ready_i)
  );

  assign rgb = {red_o, green_o, blue_o};

  always #5 clk_i = ~clk_i;

  // Independent heat-map reference using integer arithmetic.
  function automatic logic [23:0] model(int g, int m);
    int seg, f, t;
    logic [7:0] r, gr, b;
    if (m == 0) return {g[7:0], g[7:0], g[7:0]};
    seg = g / 64;
    f   = g % 64;
    t   = f * 4 + f / 16;
    case (seg)
      0:       begin r = 8'd0;         gr = t[7:0];         b = 8'd255;       end
      1:       begin r = 8'd0;         gr = 8'd255;         b = 8'(255 - t);  end
      2:       begin r = t[7:0];       gr = 8'd255;         b = 8'd0;         end
      default: begin r = 8'd255;       gr = 8'(255 - t);    b = 8'd0;         end
    endcase
    return {r, gr, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One beat with ready_i high; checks the 2-edge latency and the result.
  task automatic applyStimulus(input logic [7:0] g, input logic m, input logic [23:0] exp, input string name);
    @(posedge clk_i); #1;
    valid_i = 1'b1; gray_i = g; mode_i = m; ready_i = 1'b1;
    #1;
    checkOutput({name, " ready_o"}, 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    checkOutput({name, " early valid"}, 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput({name, " valid"}, 32'(valid_o), 32'd1);
    checkOutput({name, " rgb"}, 32'(rgb), 32'(exp));
  endtask

  initial begin
    logic [7:0] grays[3];
    int beat, got, sent, recv, cyc;

    vecs[0]  = '{8'h5A, 1'b0, 24'h5A5A5A};
    vecs[1]  = '{8'h00, 1'b1, 24'h0000FF};
    vecs[2]  = '{8'h40, 1'b1, 24'h00FFFF};
    vecs[3]  = '{8'h7F, 1'b1, 24'h00FF00};
    vecs[4]  = '{8'h9A, 1'b1, 24'h69FF00};
    vecs[5]  = '{8'hC0, 1'b1, 24'hFFFF00};
    vecs[6]  = '{8'hFF, 1'b1, 24'hFF0000};
    vecs[7]  = '{8'hFF, 1'b0, 24'hFFFFFF};
    vecs[8]  = '{8'h00, 1'b0, 24'h000000};
    vecs[9]  = '{8'h3F, 1'b1, 24'h00FFFF};
    vecs[10] = '{8'h20, 1'b1, 24'h0082FF};
    vecs[11] = '{8'h55, 1'b1, 24'h00FFAA};
    vecs[12] = '{8'h80, 1'b1, 24'h00FF00};
    vecs[13] = '{8'hBF, 1'b1, 24'hFFFF00};
    vecs[14] = '{8'hE0, 1'b1, 24'hFF7D00};
    vecs[15] = '{8'hA5, 1'b0, 24'hA5A5A5};

    reset_ni = 1'b0; valid_i = 1'b0; gray_i = '0; mode_i = 1'b0; ready_i = 1'b0;
    #2;
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset rgb", 32'(rgb), 32'd0);
    checkOutput("reset ready_o", 32'(ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_ni = 1'b1;

    for (int i = 0; i < 16; i++)
      applyStimulus(vecs[i].gray, vecs[i].mode, vecs[i].rgb, $sformatf("vec%0d", i));

    // Back-to-back beats with ready_i high: no bubble, consecutive outputs.
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = (i < 6); gray_i = 8'(i * 16 + 3); mode_i = 1'b0;
      #1;
      checkOutput("burst ready_o", 32'(ready_o), 32'd1);
      if (i >= 2) begin
        checkOutput("burst valid", 32'(valid_o), 32'd1);
        checkOutput("burst rgb", 32'(rgb), 32'(model((i - 2) * 16 + 3, 0)));
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1;

    // Backpressure: three beats offered while ready_i is low.
    grays[0] = 8'h10; grays[1] = 8'h20; grays[2] = 8'h30;
    ready_i = 1'b0; beat = 0;
    for (int c = 0; c < 5; c++) begin
      valid_i = (beat < 3); gray_i = (beat < 3) ? grays[beat] : 8'h00; mode_i = 1'b0;
      #1;
      if (c >= 2) begin
        checkOutput("bp ready_o", 32'(ready_o), 32'd0);
        checkOutput("bp valid_o", 32'(valid_o), 32'd1);
        checkOutput("bp hold rgb", 32'(rgb), 32'h101010);
      end
      if (valid_i && ready_o) beat++;
      @(posedge clk_i); #1;
    end
    checkOutput("bp accepted", 32'(beat), 32'd2);
    ready_i = 1'b1; got = 0;
    for (int c = 0; c < 12; c++) begin
      valid_i = (beat < 3); gray_i = (beat < 3) ? grays[beat] : 8'h00;
      #1;
      if (valid_o && ready_i) begin
        if (got < 3) checkOutput("bp drain rgb", 32'(rgb), 32'(model(grays[got], 0)));
        got++;
      end
      if (valid_i && ready_o) beat++;
      @(posedge clk_i); #1;
    end
    checkOutput("bp drained count", 32'(got), 32'd3);

    // Streaming 0..255 in heat mode with random downstream readiness.
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 256 || recv < 256) && cyc < 5000) begin
      valid_i = (sent < 256); gray_i = 8'(sent); mode_i = 1'b1;
      ready_i = 1'($urandom_range(0, 1));
      #1;
      if (valid_o && ready_i) begin
        if (recv < 256) checkOutput($sformatf("stream beat %0d", recv), 32'(rgb), 32'(model(recv, 1)));
        recv++;
      end
      if (valid_i && ready_o) sent++;
      @(posedge clk_i); #1;
      cyc++;
    end
    checkOutput("stream sent", 32'(sent), 32'd256);
    checkOutput("stream received", 32'(recv), 32'd256);
    valid_i = 1'b0; ready_i = 1'b1;
    #1;
    checkOutput("stream no extra", 32'(valid_o), 32'd0);

    // Asynchronous reset with two beats in flight.
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; gray_i = 8'h11; mode_i = 1'b0;
    @(posedge clk_i); #1;
    gray_i = 8'h22;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    checkOutput("pre-reset valid", 32'(valid_o), 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    checkOutput("async reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("async reset rgb", 32'(rgb), 32'd0);
    checkOutput("async reset ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i) reset_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      checkOutput("no stale beat", 32'(valid_o), 32'd0);
    end
    applyStimulus(8'h33, 1'b0, 24'h333333, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
